mem_arbiter: RTL

Shares one single-ported memory bus between the core's instruction-fetch port and data port. Sits between `core` and the unified memory model/SRAM. Arbitrates with fixed data-over-fetch priority and holds one outstanding transaction at a time. Returns per-requester grant and read-valid pulses, from which the core's stall logic is derived.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_pick.sv | 57 +++++
 rtl/mem_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP
   } arb_state_t;

   typedef enum logic {
      OWN_I,
      OWN_D
   } arb_owner_t;

   localparam logic [2:0]  SIZE_WORD    = 3'b010;
   localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requests; data wins unless the optional
// fetch anti-starvation counter (MEM_ARB_STARVE_EN) says fetch is due.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4
) (
`ifdef MEM_ARB_STARVE_EN
   input  logic clk,
   input  logic rst,
`endif
   input  logic idle_i,
   input  logic i_req_i,
   input  logic d_req_i,
   output logic i_gnt_o,
   output logic d_gnt_o
);

   logic fetch_win_c;

`ifdef MEM_ARB_STARVE_EN
   localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

   logic [STARVE_CNT_W-1:0] cnt_q;
   logic [STARVE_CNT_W-1:0] cnt_d;

   assign fetch_win_c = i_req_i && (!d_req_i || (cnt_q == STARVE_LIM));

   // Counts data grants that overtook a waiting fetch.
   always_comb begin
      cnt_d = cnt_q;
      if (i_gnt_o) begin
         cnt_d = '0;
      end else if (d_gnt_o && i_req_i) begin
         cnt_d = cnt_q + STARVE_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   // STARVE_MAX has no effect without the starvation counter.
   logic unused_starve_c;
   assign unused_starve_c = (STARVE_MAX == 0);

   assign fetch_win_c = i_req_i && !d_req_i;
`endif

   assign i_gnt_o = idle_i && fetch_win_c;
   assign d_gnt_o = idle_i && d_req_i && !fetch_win_c;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and data ports,
// one outstanding transaction at a time. Optional fetch anti-starvation: MEM_ARB_STARVE_EN.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [2:0]        d_size,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic [2:0]        m_size,
   input  logic              m_ready,
   input  logic              m_rvalid,
   input  logic [DATA_W-1:0] m_rdata
);

   arb_state_t        state_q;
   arb_owner_t        owner_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [2:0]        size_q;
   logic              idle_c;
   logic              rvalid_c;

   assign idle_c = (state_q == IDLE) && !rst;

   mem_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
`ifdef MEM_ARB_STARVE_EN
      .clk     (clk),
      .rst     (rst),
`endif
      .idle_i  (idle_c),
      .i_req_i (i_req),
      .d_req_i (d_req),
      .i_gnt_o (i_gnt),
      .d_gnt_o (d_gnt)
   );

   // Transaction FSM: latch the winner, present it to memory, wait for read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= OWN_I;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (d_gnt) begin
                  owner_q <= OWN_D;
                  we_q    <= d_we;
                  addr_q  <= d_addr;
                  wdata_q <= d_wdata;
                  size_q  <= d_size;
                  state_q <= REQ;
               end else if (i_gnt) begin
                  owner_q <= OWN_I;
                  we_q    <= 1'b0;
                  addr_q  <= i_addr;
                  wdata_q <= '0;
                  size_q  <= SIZE_WORD;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (m_ready) begin
                  state_q <= we_q ? IDLE : RESP;
               end
            end
            RESP: begin
               if (m_rvalid) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Bus fields read as zero whenever no request is being presented.
   assign m_req   = (state_q == REQ) && !rst;
   assign m_we    = m_req && we_q;
   assign m_addr  = m_req ? addr_q  : '0;
   assign m_wdata = m_req ? wdata_q : '0;
   assign m_size  = m_req ? size_q  : '0;

   assign rvalid_c = (state_q == RESP) && m_rvalid && !rst;
   assign i_rvalid = rvalid_c && (owner_q == OWN_I);
   assign d_rvalid = rvalid_c && (owner_q == OWN_D);
   assign i_rdata  = i_rvalid ? m_rdata : '0;
   assign d_rdata  = d_rvalid ? m_rdata : '0;

endmodule
